// File: rtl/vote_sequencer_pkg.sv
// Shared types and helpers for the 2-of-3 majority round controller.
package vote_sequencer_pkg;

  localparam int NUM_VOTERS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_e;

  // Number of set bits in a 3-bit vote vector (0..3).
  function automatic logic [1:0] popcount3(input logic [NUM_VOTERS-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // 2-of-3 majority of a 3-bit vote vector.
  function automatic logic majority3(input logic [NUM_VOTERS-1:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/vote_sequencer_timer.sv
// Round timeout counter: counts enabled cycles from a clear and flags the
// cycle on which the count reaches TIMEOUT-1. TIMEOUT=0 never expires.
module vote_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear has priority over enable.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (count_q == LAST);

endmodule

// File: rtl/vote_sequencer.sv
// Round controller for a 2-of-3 majority vote: collects one vote per voter,
// then presents one registered result per round. Missing votes count as 0.
// Optional result_unan output is enabled by VOTE_SEQUENCER_UNANIMOUS_EN.
module vote_sequencer
  import vote_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOTERS-1:0] vote_val,
  input  logic [NUM_VOTERS-1:0] vote_bit,
  output logic [NUM_VOTERS-1:0] vote_rdy,
  output logic                  result_val,
  input  logic                  result_rdy,
  output logic                  result_bit,
  output logic [1:0]            result_ones,
  output logic                  result_timeout,
  output logic [CNT_W-1:0]      round_count
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
  ,
  output logic                  result_unan
`endif
);

  state_e                  state_q, state_d;
  logic [NUM_VOTERS-1:0]   got_q, got_d, bits_q, bits_d;
  logic                    res_bit_q, res_bit_d;
  logic [1:0]              res_ones_q, res_ones_d;
  logic                    res_tmo_q, res_tmo_d;
  logic [CNT_W-1:0]        round_q, round_d;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
  logic                    res_unan_q, res_unan_d;
`endif

  logic [NUM_VOTERS-1:0]   fire, got_nx, bits_nx;
  logic                    timer_clr, timer_en, expired;
  logic                    load, load_tmo;

  // Ready depends only on state, never on vote_val.
  assign vote_rdy = (state_q == RESULT) ? '0 : ~got_q;
  assign fire     = vote_val & vote_rdy;
  assign got_nx   = got_q | fire;
  assign bits_nx  = (bits_q & ~fire) | (vote_bit & fire);

  vote_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (timer_clr),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  // Next-state, vote capture and result latching; a full vote set beats timeout.
  always_comb begin
    state_d    = state_q;
    got_d      = got_q;
    bits_d     = bits_q;
    res_bit_d  = res_bit_q;
    res_ones_d = res_ones_q;
    res_tmo_d  = res_tmo_q;
    round_d    = round_q;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
    res_unan_d = res_unan_q;
`endif
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    load       = 1'b0;
    load_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        got_d  = got_nx;
        bits_d = bits_nx;
        if (got_nx == '1) begin
          state_d = RESULT;
          load    = 1'b1;
        end else if (|fire) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        got_d     = got_nx;
        bits_d    = bits_nx;
        if (got_nx == '1) begin
          state_d = RESULT;
          load    = 1'b1;
        end else if (expired) begin
          state_d  = RESULT;
          load     = 1'b1;
          load_tmo = 1'b1;
        end
      end
      RESULT: begin
        if (result_rdy) begin
          state_d    = IDLE;
          got_d      = '0;
          bits_d     = '0;
          res_bit_d  = 1'b0;
          res_ones_d = 2'd0;
          res_tmo_d  = 1'b0;
          round_d    = round_q + CNT_W'(1);
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
          res_unan_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      res_bit_d  = majority3(bits_nx & got_nx);
      res_ones_d = popcount3(bits_nx & got_nx);
      res_tmo_d  = load_tmo;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
      res_unan_d = (got_nx == '1) && ((bits_nx == '0) || (bits_nx == '1));
`endif
    end
  end

  // State and result registers; reset discards any partial round.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      got_q      <= '0;
      bits_q     <= '0;
      res_bit_q  <= 1'b0;
      res_ones_q <= 2'd0;
      res_tmo_q  <= 1'b0;
      round_q    <= '0;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
      res_unan_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      got_q      <= got_d;
      bits_q     <= bits_d;
      res_bit_q  <= res_bit_d;
      res_ones_q <= res_ones_d;
      res_tmo_q  <= res_tmo_d;
      round_q    <= round_d;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
      res_unan_q <= res_unan_d;
`endif
    end
  end

  assign result_val     = (state_q == RESULT);
  assign result_bit     = res_bit_q;
  assign result_ones    = res_ones_q;
  assign result_timeout = res_tmo_q;
  assign round_count    = round_q;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
  assign result_unan    = res_unan_q;
`endif

endmodule

// File: tb/tb_vote_sequencer.sv
// Directed bench for vote_sequencer: instance a uses TIMEOUT=16, instance b
// uses TIMEOUT=4 for the timeout scenarios.
module tb_vote_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] vote_val_a = '0, vote_bit_a = '0, vote_rdy_a;
  logic       result_val_a, result_rdy_a = 1'b0, result_bit_a, result_timeout_a;
  logic [1:0] result_ones_a;
  logic [7:0] round_count_a;
  logic [2:0] vote_val_b = '0, vote_bit_b = '0, vote_rdy_b;
  logic       result_val_b, result_rdy_b = 1'b0, result_bit_b, result_timeout_b;
  logic [1:0] result_ones_b;
  logic [7:0] round_count_b;
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
  logic       result_unan_a, result_unan_b;
`endif

  int total = 0;
  int bad = 0;
  int rounds_a = 0;
  int rounds_b = 0;
  logic [4:0] obs;

  always #5 clk = ~clk;

  vote_sequencer #(.TIMEOUT(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .vote_val(vote_val_a), .vote_bit(vote_bit_a), .vote_rdy(vote_rdy_a),
    .result_val(result_val_a), .result_rdy(result_rdy_a),
    .result_bit(result_bit_a), .result_ones(result_ones_a),
    .result_timeout(result_timeout_a), .round_count(round_count_a)
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
    , .result_unan(result_unan_a)
`endif
  );

  vote_sequencer #(.TIMEOUT(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .vote_val(vote_val_b), .vote_bit(vote_bit_b), .vote_rdy(vote_rdy_b),
    .result_val(result_val_b), .result_rdy(result_rdy_b),
    .result_bit(result_bit_b), .result_ones(result_ones_b),
    .result_timeout(result_timeout_b), .round_count(round_count_b)
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
    , .result_unan(result_unan_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending result on instance a and check the return to IDLE.
  task automatic accept_a(input string name);
    result_rdy_a = 1'b1;
    step();
    result_rdy_a = 1'b0;
    rounds_a++;
    obs = {result_val_a, result_bit_a, result_ones_a, result_timeout_a};
    total++;
    if (obs !== 5'b0) begin
      bad++;
      $display("FAIL %s_idle_outputs got=%b exp=00000", name, obs);
    end
    total++;
    if (vote_rdy_a !== 3'b111 || round_count_a !== 8'(rounds_a)) begin
      bad++;
      $display("FAIL %s_after_accept rdy=%b round=%0d exp rdy=111 round=%0d",
               name, vote_rdy_a, round_count_a, rounds_a);
    end
  endtask

  task automatic accept_b(input string name);
    result_rdy_b = 1'b1;
    step();
    result_rdy_b = 1'b0;
    rounds_b++;
    total++;
    if (result_val_b !== 1'b0 || vote_rdy_b !== 3'b111 || round_count_b !== 8'(rounds_b)) begin
      bad++;
      $display("FAIL %s_after_accept val=%b rdy=%b round=%0d exp val=0 rdy=111 round=%0d",
               name, result_val_b, vote_rdy_b, round_count_b, rounds_b);
    end
  endtask

  task automatic test_reset();
    vote_val_a = 3'b111;
    repeat (2) step();
    obs = {result_val_a, result_bit_a, result_ones_a, result_timeout_a};
    total++;
    if (obs !== 5'b0 || vote_rdy_a !== 3'b111 || round_count_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_a out=%b rdy=%b round=%0d exp out=00000 rdy=111 round=0",
               obs, vote_rdy_a, round_count_a);
    end
    obs = {result_val_b, result_bit_b, result_ones_b, result_timeout_b};
    total++;
    if (obs !== 5'b0 || vote_rdy_b !== 3'b111 || round_count_b !== 8'd0) begin
      bad++;
      $display("FAIL reset_b out=%b rdy=%b round=%0d exp out=00000 rdy=111 round=0",
               obs, vote_rdy_b, round_count_b);
    end
    vote_val_a = 3'b000;
    reset = 1'b1;
    step();
  endtask

  // v0=0, v1=1, v2=1 all in one cycle.
  task automatic test_all_at_once();
    vote_val_a = 3'b111;
    vote_bit_a = 3'b110;
    step();
    vote_val_a = 3'b000;
    obs = {result_val_a, result_bit_a, result_ones_a, result_timeout_a};
    total++;
    if (obs !== 5'b11100) begin
      bad++;
      $display("FAIL all_at_once_result got=%b exp=11100", obs);
    end
    total++;
    if (vote_rdy_a !== 3'b000) begin
      bad++;
      $display("FAIL all_at_once_rdy got=%b exp=000", vote_rdy_a);
    end
    accept_a("all_at_once");
  endtask

  // v0=1 at cycle 0 (held), v2=0 at cycle 3, v1=0 at cycle 5.
  task automatic test_staggered();
    logic [2:0] exp_rdy;
    vote_val_a = 3'b001;
    vote_bit_a = 3'b001;
    step();
    for (int c = 1; c <= 5; c++) begin
      exp_rdy = (c <= 3) ? 3'b110 : 3'b010;
      total++;
      if (vote_rdy_a !== exp_rdy || result_val_a !== 1'b0) begin
        bad++;
        $display("FAIL staggered_c%0d rdy=%b val=%b exp rdy=%b val=0",
                 c, vote_rdy_a, result_val_a, exp_rdy);
      end
      vote_val_a = 3'b001 | ((c >= 3) ? 3'b100 : 3'b000) | ((c == 5) ? 3'b010 : 3'b000);
      step();
    end
    vote_val_a = 3'b000;
    obs = {result_val_a, result_bit_a, result_ones_a, result_timeout_a};
    total++;
    if (obs !== 5'b10010) begin
      bad++;
      $display("FAIL staggered_result got=%b exp=10010", obs);
    end
    accept_a("staggered");
  endtask

  // Only v1=1 votes; TIMEOUT=4 closes the round after 4 COLLECT cycles.
  task automatic test_timeout();
    vote_val_b = 3'b010;
    vote_bit_b = 3'b010;
    step();
    vote_val_b = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (result_val_b !== 1'b0) begin
        bad++;
        $display("FAIL timeout_early_c%0d val=%b exp=0", c, result_val_b);
      end
      step();
    end
    obs = {result_val_b, result_bit_b, result_ones_b, result_timeout_b};
    total++;
    if (obs !== 5'b10011) begin
      bad++;
      $display("FAIL timeout_result got=%b exp=10011", obs);
    end
    accept_b("timeout");
  endtask

  // v0,v1 vote 1 at cycle 0; v2 votes 1 on the expiry edge (cycle 4).
  task automatic test_timeout_edge();
    vote_val_b = 3'b011;
    vote_bit_b = 3'b111;
    step();
    vote_val_b = 3'b000;
    repeat (3) step();
    total++;
    if (result_val_b !== 1'b0 || vote_rdy_b !== 3'b100) begin
      bad++;
      $display("FAIL timeout_edge_pre val=%b rdy=%b exp val=0 rdy=100",
               result_val_b, vote_rdy_b);
    end
    vote_val_b = 3'b100;
    step();
    vote_val_b = 3'b000;
    obs = {result_val_b, result_bit_b, result_ones_b, result_timeout_b};
    total++;
    if (obs !== 5'b11110) begin
      bad++;
      $display("FAIL timeout_edge_result got=%b exp=11110", obs);
    end
    accept_b("timeout_edge");
  endtask

  // Votes 1,0,1; consumer stalls for 5 cycles while new votes are offered.
  task automatic test_backpressure();
    vote_val_a = 3'b111;
    vote_bit_a = 3'b101;
    step();
    vote_bit_a = 3'b000;
    for (int c = 0; c < 5; c++) begin
      obs = {result_val_a, result_bit_a, result_ones_a, result_timeout_a};
      total++;
      if (obs !== 5'b11100 || vote_rdy_a !== 3'b000) begin
        bad++;
        $display("FAIL backpressure_c%0d out=%b rdy=%b exp out=11100 rdy=000",
                 c, obs, vote_rdy_a);
      end
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
      total++;
      if (result_unan_a !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_unan_c%0d got=%b exp=0", c, result_unan_a);
      end
`endif
      step();
    end
    vote_val_a = 3'b000;
    accept_a("backpressure");
  endtask

`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
  task automatic test_unanimous();
    vote_val_a = 3'b111;
    vote_bit_a = 3'b111;
    step();
    vote_val_a = 3'b000;
    total++;
    if (result_unan_a !== 1'b1 || result_ones_a !== 2'd3) begin
      bad++;
      $display("FAIL unan_111 unan=%b ones=%0d exp unan=1 ones=3", result_unan_a, result_ones_a);
    end
    accept_a("unan_111");
    vote_val_a = 3'b111;
    vote_bit_a = 3'b101;
    step();
    vote_val_a = 3'b000;
    total++;
    if (result_unan_a !== 1'b0 || result_val_a !== 1'b1) begin
      bad++;
      $display("FAIL unan_101 unan=%b val=%b exp unan=0 val=1", result_unan_a, result_val_a);
    end
    accept_a("unan_101");
  endtask
`endif

  // Reset asserted between edges during COLLECT.
  task automatic test_async_reset();
    vote_val_a = 3'b011;
    vote_bit_a = 3'b011;
    step();
    vote_val_a = 3'b000;
    total++;
    if (vote_rdy_a !== 3'b100 || round_count_a !== 8'(rounds_a)) begin
      bad++;
      $display("FAIL async_pre rdy=%b round=%0d exp rdy=100 round=%0d",
               vote_rdy_a, round_count_a, rounds_a);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (vote_rdy_a !== 3'b111 || result_val_a !== 1'b0 || round_count_a !== 8'd0) begin
      bad++;
      $display("FAIL async_reset rdy=%b val=%b round=%0d exp rdy=111 val=0 round=0",
               vote_rdy_a, result_val_a, round_count_a);
    end
    total++;
    if (round_count_b !== 8'd0) begin
      bad++;
      $display("FAIL async_reset_b round=%0d exp=0", round_count_b);
    end
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
    total++;
    if (result_unan_a !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_unan got=%b exp=0", result_unan_a);
    end
`endif
    #1;
    reset = 1'b1;
    rounds_a = 0;
    rounds_b = 0;
    step();
    total++;
    if (vote_rdy_a !== 3'b111 || result_val_a !== 1'b0) begin
      bad++;
      $display("FAIL async_after rdy=%b val=%b exp rdy=111 val=0", vote_rdy_a, result_val_a);
    end
  endtask

  initial begin
    test_reset();
    test_all_at_once();
    test_staggered();
    test_timeout();
    test_timeout_edge();
    test_backpressure();
`ifdef VOTE_SEQUENCER_UNANIMOUS_EN
    test_unanimous();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
